// File: rtl/caxi4interconnect_ram_fifo.sv
// rtl/caxi4interconnect_ram_fifo.sv - single-clock RAM-backed FIFO with flags, count and error pulses
//
// Purpose: self-contained synchronous FIFO around an inferred dual-port RAM.
//   Occupancy and all flags are registered from the next-state count, so a
//   write into an empty FIFO becomes readable one cycle later.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   wr_en, data_in      write request and data (dropped while full)
//   rd_en               read request (ignored while empty)
//   data_out            show-ahead (REG_OUT=0) or registered (REG_OUT=1) read data
//   data_valid          REG_OUT=1: data_out holds the word popped last cycle
//                       REG_OUT=0: mirrors ~empty
//   full, empty         count == MEM_DEPTH, count == 0
//   almost_full         count >= AFULL_THRESH
//   almost_empty        count <= AEMPTY_THRESH
//   count               occupancy 0..MEM_DEPTH
//   overflow, underflow one-cycle pulses for a rejected write / read

module caxi4interconnect_ram_fifo #(
    parameter int MEM_DEPTH     = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_OUT       = 0,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter int RAM_STYLE     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_DEPTH-1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wa;
    logic                  ra;

    // Accept decisions use only registered flags: no same-cycle pass-through.
    assign wa = wr_en & ~full;
    assign ra = rd_en & ~empty;

    always_comb begin
        count_next = count;
        if (wa && !ra) begin
            count_next = count + CNT_ONE;
        end else if (ra && !wa) begin
            count_next = count - CNT_ONE;
        end
    end

    // Storage array; the write side is identical in both styles, only the
    // synthesis attribute differs.
    generate
        if (RAM_STYLE == 1) begin : g_uram
            (* syn_ramstyle = "uram" *) logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
            always_ff @(posedge clk) begin
                if (wa) begin
                    mem[wr_ptr] <= data_in;
                end
            end
            assign rd_word = mem[rd_ptr];
        end else begin : g_ram
            logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
            always_ff @(posedge clk) begin
                if (wa) begin
                    mem[wr_ptr] <= data_in;
                end
            end
            assign rd_word = mem[rd_ptr];
        end
    endgenerate

    // Pointers wrap by explicit compare so MEM_DEPTH need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wa) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (ra) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dv_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= ra;
                    if (ra) begin
                        dout_q <= rd_word;
                    end
                end
            end
            assign data_out   = dout_q;
            assign data_valid = dv_q;
        end else begin : g_show_ahead
            assign data_out   = rd_word;
            assign data_valid = ~empty;
        end
    endgenerate

endmodule
